ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter: the host-side sender for the same PS/2 link the keyboard receiver listens on.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using the PS/2 request-to-send sequence, odd parity and device acknowledge.
- Drives the open-collector clock and data lines through active-high pull-low enables.
- Asserts txBusy during a transfer so the receiver path can ignore line activity.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_host_tx.sv | 168 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, frame sizing and command codes.
package ps2_pkg;

  // Host-to-device transmit states.
  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StSend,
    StAck,
    StWaitIdle,
    StDone,
    StError
  } ps2TxState_e;

  // Start + 8 data + parity + stop.
  localparam int unsigned FrameLen = 11;
  // Bits shifted out by the host after the start bit: {stop, parity, data}.
  localparam int unsigned ShiftLen = FrameLen - 1;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_CODE    = 8'hFA;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic oddParity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchronizer, then a stability filter that only
// lets the level change after FilterLen consecutive samples agree. Emits a fall strobe.
module ps2_line_filter #(
  parameter int unsigned FilterLen = 8
) (
  input  logic boardClk,
  input  logic reset,
  input  logic lineIn,
  output logic level,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FilterLen + 1);

  logic            sync1Q, sync2Q;
  logic            levelQ, levelD;
  logic            fallQ, fallD;
  logic [CntW-1:0] stableCntQ, stableCntD;

  // Count consecutive samples that disagree with the current filtered level.
  always_comb begin
    levelD     = levelQ;
    fallD      = 1'b0;
    stableCntD = '0;
    if (sync2Q != levelQ) begin
      if (stableCntQ == CntW'(FilterLen - 1)) begin
        levelD = sync2Q;
        fallD  = ~sync2Q;
      end else begin
        stableCntD = stableCntQ + 1'b1;
      end
    end
  end

  // Lines idle high, so reset everything to the released level.
  always_ff @(posedge boardClk) begin
    if (reset) begin
      sync1Q     <= 1'b1;
      sync2Q     <= 1'b1;
      levelQ     <= 1'b1;
      fallQ      <= 1'b0;
      stableCntQ <= '0;
    end else begin
      sync1Q     <= lineIn;
      sync2Q     <= sync1Q;
      levelQ     <= levelD;
      fallQ      <= fallD;
      stableCntQ <= stableCntD;
    end
  end

  assign level = levelQ;
  assign fall  = fallQ;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, clocked-out frame, device ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned BIT_TIMEOUT    = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       boardClk,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txStart,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  output logic       txBusy,
  output logic       txDone,
  output logic       txErr
);

  localparam int unsigned MaxCycles = maxOf(INHIBIT_CYCLES, maxOf(START_TIMEOUT, BIT_TIMEOUT));
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  ps2TxState_e         stateQ, stateD;
  logic [ShiftLen-1:0] frameQ, frameD;
  logic [3:0]          bitCntQ, bitCntD;
  logic [CntW-1:0]     cntQ, cntD;
  logic                dataOeQ, dataOeD;

  logic clkLevel, clkFall, dataLevel, dataFall;
  logic unusedDataFall;

  ps2_line_filter #(
    .FilterLen(FILTER_LEN)
  ) uClkFilter (
    .boardClk(boardClk),
    .reset   (reset),
    .lineIn  (ps2ClkIn),
    .level   (clkLevel),
    .fall    (clkFall)
  );

  ps2_line_filter #(
    .FilterLen(FILTER_LEN)
  ) uDataFilter (
    .boardClk(boardClk),
    .reset   (reset),
    .lineIn  (ps2DataIn),
    .level   (dataLevel),
    .fall    (dataFall)
  );

  // Only the receiver path needs data edges.
  assign unusedDataFall = dataFall;

  // Next-state, counters and line drive. cntQ holds cycles elapsed since the last
  // reference event (clock release or device edge), counting that event's cycle as 1.
  always_comb begin
    stateD    = stateQ;
    frameD    = frameQ;
    bitCntD   = bitCntQ;
    cntD      = cntQ;
    dataOeD   = dataOeQ;
    ps2ClkOe  = 1'b0;
    ps2DataOe = 1'b0;
    txDone    = 1'b0;
    txErr     = 1'b0;
    txBusy    = (stateQ != StIdle);

    unique case (stateQ)
      StIdle: begin
        if (txStart) begin
          frameD = {1'b1, oddParity(txData), txData};
          cntD   = '0;
          stateD = StInhibit;
        end
      end

      StInhibit: begin
        ps2ClkOe = 1'b1;
        if (cntQ == CntW'(INHIBIT_CYCLES - 1)) begin
          stateD = StRts;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end

      StRts: begin
        ps2DataOe = 1'b1;
        bitCntD   = '0;
        cntD      = CntW'(1);
        dataOeD   = 1'b1;
        stateD    = StSend;
      end

      StSend: begin
        ps2DataOe = dataOeQ;
        if (clkFall) begin
          dataOeD = ~frameQ[bitCntQ];
          bitCntD = bitCntQ + 1'b1;
          cntD    = CntW'(1);
          if (bitCntQ == 4'(ShiftLen - 1)) begin
            stateD = StAck;
          end
        end else if ((bitCntQ == '0) ? (cntQ >= CntW'(START_TIMEOUT - 1))
                                     : (cntQ >= CntW'(BIT_TIMEOUT - 1))) begin
          stateD = StError;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end

      StAck: begin
        ps2DataOe = dataOeQ;
        if (clkFall) begin
          cntD   = CntW'(1);
          stateD = dataLevel ? StError : StWaitIdle;
        end else if (cntQ >= CntW'(BIT_TIMEOUT - 1)) begin
          stateD = StError;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end

      StWaitIdle: begin
        if (clkLevel && dataLevel) begin
          stateD = StDone;
        end else if (cntQ >= CntW'(BIT_TIMEOUT - 1)) begin
          stateD = StError;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end

      StDone: begin
        txDone = 1'b1;
        stateD = StIdle;
      end

      StError: begin
        txErr  = 1'b1;
        stateD = StIdle;
      end

      default: stateD = StIdle;
    endcase
  end

  // State register; reset returns to idle with both lines released.
  always_ff @(posedge boardClk) begin
    if (reset) begin
      stateQ  <= StIdle;
      frameQ  <= '0;
      bitCntQ <= '0;
      cntQ    <= '0;
      dataOeQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      frameQ  <= frameD;
      bitCntQ <= bitCntD;
      cntQ    <= cntD;
      dataOeQ <= dataOeD;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model plus a scoreboard of expected frames and outcomes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned Inh  = 60;
  localparam int unsigned Sto  = 2000;
  localparam int unsigned Bto  = 1000;
  localparam int unsigned Half = 50;

  typedef struct {
    logic        isErr;
    logic        chkLat;
    int unsigned lat;
  } outcome_t;

  logic       boardClk = 1'b0;
  logic       reset;
  logic       txStart;
  logic [7:0] txData;
  logic       devClk  = 1'b1;
  logic       devData = 1'b1;
  logic       ps2ClkIn, ps2DataIn;
  logic       ps2ClkOe, ps2DataOe, txBusy, txDone, txErr;

  // Open-collector wiring: either side can pull a line low.
  assign ps2ClkIn  = devClk & ~ps2ClkOe;
  assign ps2DataIn = devData & ~ps2DataOe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inh),
    .START_TIMEOUT (Sto),
    .BIT_TIMEOUT   (Bto),
    .FILTER_LEN    (8)
  ) dut (
    .boardClk (boardClk),
    .reset    (reset),
    .txData   (txData),
    .txStart  (txStart),
    .ps2ClkIn (ps2ClkIn),
    .ps2DataIn(ps2DataIn),
    .ps2ClkOe (ps2ClkOe),
    .ps2DataOe(ps2DataOe),
    .txBusy   (txBusy),
    .txDone   (txDone),
    .txErr    (txErr)
  );

  always #5 boardClk = ~boardClk;

  int unsigned cycle = 0;
  always @(posedge boardClk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  outcome_t    expOutQ[$];
  logic [9:0]  expFrameQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome monitor: pops the expected result whenever the DUT pulses done or error.
  logic        prevClkOe = 1'b0;
  logic        busyCheckPending = 1'b0;
  int unsigned releaseCycle = 0;
  always @(negedge boardClk) begin
    outcome_t e;
    if (prevClkOe && !ps2ClkOe) releaseCycle <= cycle;
    prevClkOe <= ps2ClkOe;
    if (busyCheckPending) check("busy_low_after_done", {31'b0, txBusy}, 0);
    busyCheckPending <= txDone;
    if (txDone || txErr) begin
      check("done_err_exclusive", {31'b0, txDone & txErr}, 0);
      if (expOutQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outcome: got done=%0b err=%0b expected none", txDone, txErr);
      end else begin
        e = expOutQ.pop_front();
        check("outcome_is_err", {31'b0, txErr}, {31'b0, e.isErr});
        if (e.chkLat) check("start_timeout_latency", cycle - releaseCycle, e.lat);
        if (txErr) check("err_lines_released", {30'b0, ps2ClkOe, ps2DataOe}, 0);
      end
    end
  end

  // Device model: checks inhibit length, clocks the frame in, optionally ACKs.
  task automatic devRun(input bit clocks, input bit ack, input bit glitch, input bit poke,
                        input int abortEdge);
    int unsigned n = 0;
    int unsigned inh = 0;
    logic [9:0]  rx = '0;
    logic [9:0]  exp;
    while (!ps2ClkOe && n < 1000) begin @(negedge boardClk); n++; end
    while (ps2ClkOe && inh < 10 * Inh) begin @(negedge boardClk); inh++; end
    check("inhibit_cycles", inh, Inh);
    check("rts_data_low", {31'b0, ps2DataOe}, 1);
    if (!clocks) return;
    repeat (20) @(negedge boardClk);
    check("start_bit", {31'b0, ps2DataIn}, 0);
    for (int k = 1; k <= 11; k++) begin
      devClk = 1'b0;
      if (k == abortEdge) begin
        repeat (20) @(negedge boardClk);
        expOutQ.delete();
        expFrameQ.delete();
        reset  = 1'b1;
        devClk = 1'b1;
        devData = 1'b1;
        @(negedge boardClk);
        reset = 1'b0;
        check("abort_lines_busy", {29'b0, ps2ClkOe, ps2DataOe, txBusy}, 0);
        return;
      end
      if (poke && k == 2) begin
        repeat (10) @(negedge boardClk);
        txData  = 8'h55;
        txStart = 1'b1;
        @(negedge boardClk);
        txStart = 1'b0;
        repeat (Half - 11) @(negedge boardClk);
      end else if (glitch && (k == 3 || k == 6)) begin
        repeat (20) @(negedge boardClk);
        devClk = 1'b1;
        repeat (3) @(negedge boardClk);
        devClk = 1'b0;
        repeat (Half - 23) @(negedge boardClk);
      end else begin
        repeat (Half) @(negedge boardClk);
      end
      devClk = 1'b1;
      if (k == 11) devData = 1'b1;
      if (glitch && k == 4) begin
        repeat (10) @(negedge boardClk);
        devClk = 1'b0;
        repeat (3) @(negedge boardClk);
        devClk = 1'b1;
        repeat (Half / 2 - 13) @(negedge boardClk);
      end else begin
        repeat (Half / 2) @(negedge boardClk);
      end
      if (k <= 10) rx[k-1] = ps2DataIn;
      if (k == 10 && ack) devData = 1'b0;
      repeat (Half - Half / 2) @(negedge boardClk);
    end
    if (expFrameQ.size() != 0) begin
      exp = expFrameQ.pop_front();
      check("frame_bits", {22'b0, rx}, {22'b0, exp});
    end
  endtask

  // One transfer: queue expectations, request, run the device, wait for the outcome.
  task automatic send(input logic [7:0] d, input logic [9:0] expFrame, input bit clocks,
                      input bit ack, input bit glitch, input bit poke, input int abortEdge);
    outcome_t e;
    int unsigned n = 0;
    e.isErr  = !(clocks && ack);
    e.chkLat = !clocks;
    e.lat    = Sto;
    expOutQ.push_back(e);
    if (clocks) expFrameQ.push_back(expFrame);
    txData  = d;
    txStart = 1'b1;
    @(negedge boardClk);
    txStart = 1'b0;
    check("busy_after_accept", {31'b0, txBusy}, 1);
    devRun(clocks, ack, glitch, poke, abortEdge);
    while (expOutQ.size() != 0 && n < 5 * Sto) begin @(negedge boardClk); n++; end
    if (expOutQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL outcome_wait: got no done/err pulse expected one within %0d cycles", 5 * Sto);
      expOutQ.delete();
    end
    repeat (20) @(negedge boardClk);
  endtask

  initial begin
    reset   = 1'b1;
    txStart = 1'b0;
    txData  = 8'h00;
    repeat (3) @(negedge boardClk);
    check("reset_outputs", {27'b0, ps2ClkOe, ps2DataOe, txBusy, txDone, txErr}, 0);
    reset = 1'b0;
    repeat (20) @(negedge boardClk);

    // Frames are {stop, parity, data}; parity makes the total ones count odd.
    send(CMD_SET_LED, 10'h3ED, 1, 1, 0, 0, 0);
    send(CMD_ENABLE,  10'h2F4, 1, 1, 0, 0, 0);
    send(8'h00,       10'h300, 1, 1, 0, 0, 0);
    send(CMD_ENABLE,  10'h2F4, 0, 0, 0, 0, 0);
    send(CMD_ENABLE,  10'h2F4, 1, 0, 0, 0, 0);
    send(CMD_SET_LED, 10'h3ED, 1, 1, 0, 0, 5);
    send(CMD_RESET,   10'h3FF, 1, 1, 0, 0, 0);
    send(8'hA5,       10'h3A5, 1, 1, 1, 1, 0);

    check("idle_no_requeue", {30'b0, txBusy, ps2ClkOe}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
